// File: rtl/eoc_status_pkg.sv
// Shared definitions for the EOC/status peripheral: register offsets, status bits, watchdog states.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package eoc_status_pkg;

    // Byte offsets of the memory-mapped registers
    localparam logic [5:0] EOC_OFF       = 6'h00;
    localparam logic [5:0] EXIT_CODE_OFF = 6'h04;
    localparam logic [5:0] CYCLE_LO_OFF  = 6'h08;
    localparam logic [5:0] CYCLE_HI_OFF  = 6'h0C;
    localparam logic [5:0] WDT_LIMIT_OFF = 6'h10;
    localparam logic [5:0] WDT_KICK_OFF  = 6'h14;
    localparam logic [5:0] STATUS_OFF    = 6'h18;

    // Bit positions inside the STATUS register
    localparam int STATUS_DONE_BIT    = 0;
    localparam int STATUS_TIMEOUT_BIT = 1;

    typedef enum logic [1:0] {
        WDT_IDLE,
        WDT_RUN,
        WDT_EXPIRED
    } wdt_state_e;

    // Word index used by the decoder (addr[5:2])
    function automatic logic [3:0] reg_idx(input logic [5:0] off);
        return 4'(off >> 2);
    endfunction

endpackage

// File: rtl/eoc_status_if.sv
// Simple peripheral bus: req/we/addr/wdata request, gnt/err same cycle, rvalid/rdata next cycle.
// Latency: response one cycle after the request.
// Backpressure: none; every request is granted in the cycle it is presented.
interface bus_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;

    modport master (output req, we, addr, wdata, input  gnt, rvalid, rdata, err);
    modport slave  (input  req, we, addr, wdata, output gnt, rvalid, rdata, err);
endinterface

// File: rtl/eoc_status_wdt.sv
// Watchdog: 32-bit down-counter plus IDLE/RUN/EXPIRED FSM; pulses o_expire on the expiry edge.
// Latency: expiry lands exactly LIMIT cycles after the last reload (or IDLE->RUN entry).
// Backpressure: none; reload/clear are single-cycle strobes always accepted.
module eoc_wdt
    import eoc_status_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] i_limit,   // limit value as of this cycle (includes an in-flight write)
    input  logic        i_reload,
    input  logic        i_clear,
    input  logic        i_done,
    output logic        o_expire,
    output logic        o_timeout
);

    wdt_state_e  r_state, w_state_nxt;
    logic [31:0] r_cnt, w_cnt_nxt;
    logic        r_timeout;

    // State and counter registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= WDT_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next state / counter; a reload takes priority over the cnt==1 expiry check
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        o_expire    = 1'b0;
        case (r_state)
            WDT_IDLE: begin
                // Track the limit so entering RUN always starts a full period
                w_cnt_nxt = i_limit;
                if (i_limit != '0 && !i_done) w_state_nxt = WDT_RUN;
            end
            WDT_RUN: begin
                if (i_limit == '0 || i_done) begin
                    w_state_nxt = WDT_IDLE;
                    w_cnt_nxt   = i_limit;
                end else if (i_reload) begin
                    w_cnt_nxt = i_limit;
                end else if (r_cnt == 32'd1) begin
                    w_state_nxt = WDT_EXPIRED;
                    o_expire    = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - 32'd1;
                end
            end
            WDT_EXPIRED: begin
                if (i_clear || i_limit == '0) w_state_nxt = WDT_IDLE;
            end
            default: w_state_nxt = WDT_IDLE;
        endcase
    end

    // Sticky timeout flag; a same-cycle expiry beats the software clear
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)       r_timeout <= 1'b0;
        else if (o_expire) r_timeout <= 1'b1;
        else if (i_clear)  r_timeout <= 1'b0;
    end

    assign o_timeout = r_timeout;

endmodule

// File: rtl/eoc_status_unit.sv
// EOC/status slave: per-channel EOC flags, exit code, freezing cycle counter, watchdog; optional irq (EOC_STATUS_IRQ_EN).
// Latency: gnt/err combinational, rvalid/rdata registered one cycle after req.
// Backpressure: none; gnt mirrors req so every request completes.
module eoc_status_unit
    import eoc_status_pkg::*;
#(
    parameter int unsigned NUM_CH        = 4,
    parameter int unsigned CNT_W         = 64,
    parameter logic [31:0] WDT_EXIT_CODE = 32'hDEAD_0001
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    bus_if.slave              bus,
    output logic [NUM_CH-1:0] eoc_o,
    output logic              done_o,
    output logic              timeout_o,
    output logic              irq_o
);

    localparam int unsigned HI_W = CNT_W - 32;

    logic [NUM_CH-1:0] r_eoc;
    logic [31:0]       r_exit_code;
    logic [CNT_W-1:0]  r_cnt;
    logic [HI_W-1:0]   r_shadow;
    logic [31:0]       r_wdt_limit;
    logic              r_rvalid;
    logic [31:0]       r_rdata;

    logic [3:0]  w_idx;
    logic        w_wr, w_rd, w_unmapped;
    logic        w_wr_eoc, w_wr_exit, w_wr_cyc_lo, w_wr_limit, w_wr_kick, w_clear;
    logic        w_rd_cyc_lo, w_expire;
    logic [31:0] w_limit_nxt, w_rd_dat;
    logic        w_unused_addr;

    assign w_idx       = bus.addr[5:2];
    assign w_unmapped  = w_idx > reg_idx(STATUS_OFF);
    assign w_wr        = bus.req &  bus.we & ~w_unmapped;
    assign w_rd        = bus.req & ~bus.we;
    assign w_wr_eoc    = w_wr && w_idx == reg_idx(EOC_OFF);
    assign w_wr_exit   = w_wr && w_idx == reg_idx(EXIT_CODE_OFF);
    assign w_wr_cyc_lo = w_wr && w_idx == reg_idx(CYCLE_LO_OFF);
    assign w_wr_limit  = w_wr && w_idx == reg_idx(WDT_LIMIT_OFF);
    assign w_wr_kick   = w_wr && w_idx == reg_idx(WDT_KICK_OFF);
    assign w_clear     = w_wr && w_idx == reg_idx(STATUS_OFF) && bus.wdata[STATUS_TIMEOUT_BIT];
    assign w_rd_cyc_lo = w_rd && w_idx == reg_idx(CYCLE_LO_OFF);
    assign w_limit_nxt = w_wr_limit ? bus.wdata : r_wdt_limit;
    assign w_unused_addr = ^{bus.addr[31:6], bus.addr[1:0]};

    assign bus.gnt    = bus.req;
    assign bus.err    = bus.req & w_unmapped;
    assign bus.rvalid = r_rvalid;
    assign bus.rdata  = r_rdata;

    assign eoc_o  = r_eoc;
    assign done_o = &r_eoc;

    eoc_wdt u_wdt (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .i_limit   (w_limit_nxt),
        .i_reload  (w_wr_limit | w_wr_kick),
        .i_clear   (w_clear),
        .i_done    (done_o),
        .o_expire  (w_expire),
        .o_timeout (timeout_o)
    );

    // EOC flags and exit code; watchdog expiry overrides a same-cycle software write
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_eoc       <= '0;
            r_exit_code <= '0;
        end else if (w_expire) begin
            r_eoc       <= '1;
            r_exit_code <= WDT_EXIT_CODE;
        end else begin
            if (w_wr_eoc)  r_eoc       <= bus.wdata[NUM_CH-1:0];
            if (w_wr_exit) r_exit_code <= bus.wdata;
        end
    end

    // Run-time counter: cleared by a CYCLE_LO write, frozen once all channels are done
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)          r_cnt <= '0;
        else if (w_wr_cyc_lo) r_cnt <= '0;
        else if (!done_o)     r_cnt <= r_cnt + CNT_W'(1);
    end

    // Watchdog limit register and the high-half snapshot taken on CYCLE_LO reads
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wdt_limit <= '0;
            r_shadow    <= '0;
        end else begin
            if (w_wr_limit)  r_wdt_limit <= bus.wdata;
            if (w_rd_cyc_lo) r_shadow    <= r_cnt[CNT_W-1:32];
        end
    end

    // Read data mux for mapped registers; write-only and unmapped words read as zero
    always_comb begin
        w_rd_dat = '0;
        case (w_idx)
            reg_idx(EOC_OFF):       w_rd_dat = 32'(r_eoc);
            reg_idx(EXIT_CODE_OFF): w_rd_dat = r_exit_code;
            reg_idx(CYCLE_LO_OFF):  w_rd_dat = r_cnt[31:0];
            reg_idx(CYCLE_HI_OFF):  w_rd_dat = 32'(r_shadow);
            reg_idx(WDT_LIMIT_OFF): w_rd_dat = r_wdt_limit;
            reg_idx(STATUS_OFF): begin
                w_rd_dat[STATUS_DONE_BIT]    = done_o;
                w_rd_dat[STATUS_TIMEOUT_BIT] = timeout_o;
            end
            default: w_rd_dat = '0;
        endcase
    end

    // Registered response: rvalid for every request, data only for reads
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
        end else begin
            r_rvalid <= bus.req;
            r_rdata  <= w_rd ? w_rd_dat : '0;
        end
    end

`ifdef EOC_STATUS_IRQ_EN
    logic r_done_q;

    // Previous done_o, for rising-edge detection
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_done_q <= 1'b0;
        else         r_done_q <= done_o;
    end

    assign irq_o = done_o & ~r_done_q;
`else
    assign irq_o = 1'b0;
`endif

endmodule

// File: tb/tb_eoc_status_unit.sv
// Directed bench for eoc_status_unit: register access, counter, watchdog, unmapped access, async reset.
// Latency: checks rvalid/rdata one cycle after each request.
// Backpressure: n/a (bench).
module tb_eoc_status_unit;
    import eoc_status_pkg::*;

    logic clk_i = 1'b0;
    logic rst_ni;
    logic [3:0] eoc_o;
    logic done_o, timeout_o, irq_o;
    int vectors = 0;
    int miscompares = 0;
    logic [31:0] rd;

    bus_if bus();

    eoc_status_unit #(.NUM_CH(4), .CNT_W(64), .WDT_EXIT_CODE(32'hDEAD_0001)) dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .bus       (bus),
        .eoc_o     (eoc_o),
        .done_o    (done_o),
        .timeout_o (timeout_o),
        .irq_o     (irq_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk_i);
        bus.req = 1'b1; bus.we = 1'b1; bus.addr = a; bus.wdata = d;
        @(posedge clk_i); #1;
        bus.req = 1'b0; bus.we = 1'b0;
        chk("wr_rvalid", bus.rvalid, 1);
        chk("wr_rdata", bus.rdata, 0);
    endtask

    task automatic bus_rd(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk_i);
        bus.req = 1'b1; bus.we = 1'b0; bus.addr = a; bus.wdata = '0;
        @(posedge clk_i); #1;
        bus.req = 1'b0;
        chk("rd_rvalid", bus.rvalid, 1);
        d = bus.rdata;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete, required finish before 200000");
        $fatal(1, "bench timeout");
    end

    initial begin
        rst_ni = 1'b0;
        bus.req = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wdata = '0;
        #12;
        chk("rst_eoc", eoc_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_timeout", timeout_o, 0);
        chk("rst_irq", irq_o, 0);
        chk("rst_rvalid", bus.rvalid, 0);
        chk("rst_rdata", bus.rdata, 0);
        @(negedge clk_i); rst_ni = 1'b1;

        bus_rd(32'(EOC_OFF), rd);            chk("eoc_after_rst", rd, 0);

        // Counter: clear, wait 100 cycles, read
        bus_wr(32'(CYCLE_LO_OFF), 32'h0);
        repeat (100) @(posedge clk_i);
        bus_rd(32'(CYCLE_LO_OFF), rd);       chk("cyc_lo_100", rd, 100);
        bus_rd(32'(CYCLE_HI_OFF), rd);       chk("cyc_hi_0", rd, 0);

        // Counter above 2^32: HI snapshot taken by the LO read
        force dut.r_cnt = 64'h1_0000_0005;
        bus_rd(32'(CYCLE_LO_OFF), rd);       chk("cyc_lo_forced", rd, 5);
        release dut.r_cnt;
        bus_rd(32'(CYCLE_HI_OFF), rd);       chk("cyc_hi_shadow", rd, 1);

        // All channels done: counter freezes at 1 (cleared, one more increment before done)
        bus_wr(32'(CYCLE_LO_OFF), 32'h0);
        bus_wr(32'(EOC_OFF), 32'hF);
        chk("done_set", done_o, 1);
        chk("eoc_all", eoc_o, 4'hF);
`ifdef EOC_STATUS_IRQ_EN
        chk("irq_pulse_sw", irq_o, 1);
`else
        chk("irq_tied", irq_o, 0);
`endif
        @(posedge clk_i); #1;
        chk("irq_one_cycle", irq_o, 0);
        bus_rd(32'(STATUS_OFF), rd);         chk("status_done", rd, 1);
        @(posedge clk_i); #1;
        chk("rvalid_drops", bus.rvalid, 0);
        bus_rd(32'(CYCLE_LO_OFF), rd);       chk("cyc_frozen_a", rd, 1);
        repeat (10) @(posedge clk_i);
        bus_rd(32'(CYCLE_LO_OFF), rd);       chk("cyc_frozen_b", rd, 1);

        // Upper EOC bits ignored
        bus_wr(32'(EOC_OFF), 32'hFFFF_FFF3);
        bus_rd(32'(EOC_OFF), rd);            chk("eoc_masked", rd, 3);
        chk("done_clr", done_o, 0);
        bus_wr(32'(EXIT_CODE_OFF), 32'h0000_1234);
        bus_rd(32'(EXIT_CODE_OFF), rd);      chk("exit_rw", rd, 32'h1234);

        // Watchdog expiry exactly 50 cycles after the limit write
        bus_wr(32'(WDT_LIMIT_OFF), 32'd50);
        repeat (49) @(posedge clk_i); #1;
        chk("wdt_not_yet", timeout_o, 0);
        @(posedge clk_i); #1;
        chk("wdt_expired", timeout_o, 1);
        chk("wdt_eoc", eoc_o, 4'hF);
`ifdef EOC_STATUS_IRQ_EN
        chk("irq_pulse_wdt", irq_o, 1);
`else
        chk("irq_tied_wdt", irq_o, 0);
`endif
        bus_rd(32'(EXIT_CODE_OFF), rd);      chk("wdt_exit", rd, 32'hDEAD_0001);
        bus_rd(32'(EOC_OFF), rd);            chk("wdt_eoc_rd", rd, 32'hF);
        bus_rd(32'(STATUS_OFF), rd);         chk("status_to", rd, 3);
        bus_rd(32'(WDT_LIMIT_OFF), rd);      chk("limit_rd", rd, 50);
        bus_wr(32'(STATUS_OFF), 32'h2);
        chk("w1c", timeout_o, 0);

        // Periodic kicks keep the watchdog quiet
        bus_wr(32'(EOC_OFF), 32'h0);
        for (int k = 0; k < 13; k++) begin
            repeat (36) @(posedge clk_i);
            bus_wr(32'(WDT_KICK_OFF), 32'h0);
        end
        chk("kicked_quiet", timeout_o, 0);
        // Kick lands on the cnt==1 cycle: no expiry, next expiry 50 cycles later
        repeat (49) @(posedge clk_i);
        bus_wr(32'(WDT_KICK_OFF), 32'h0);
        chk("kick_at_one", timeout_o, 0);
        repeat (49) @(posedge clk_i); #1;
        chk("kick_reloaded", timeout_o, 0);
        @(posedge clk_i); #1;
        chk("kick_then_expire", timeout_o, 1);

        // W1C coincident with expiry: flag stays set
        bus_wr(32'(STATUS_OFF), 32'h2);
        bus_wr(32'(EOC_OFF), 32'h0);
        bus_wr(32'(WDT_LIMIT_OFF), 32'd50);
        repeat (49) @(posedge clk_i);
        bus_wr(32'(STATUS_OFF), 32'h2);
        chk("w1c_vs_expiry", timeout_o, 1);
        bus_wr(32'(STATUS_OFF), 32'h2);
        chk("w1c_after", timeout_o, 0);

        // Unmapped accesses
        @(negedge clk_i);
        bus.req = 1'b1; bus.we = 1'b0; bus.addr = 32'h1C; #1;
        chk("unmapped_gnt", bus.gnt, 1);
        chk("unmapped_err", bus.err, 1);
        @(posedge clk_i); #1;
        bus.req = 1'b0;
        chk("unmapped_rvalid", bus.rvalid, 1);
        chk("unmapped_rdata", bus.rdata, 0);
        @(negedge clk_i);
        bus.req = 1'b1; bus.addr = 32'(STATUS_OFF); #1;
        chk("mapped_err", bus.err, 0);
        @(posedge clk_i); #1;
        bus.req = 1'b0;
        bus_wr(32'h20, 32'h0);
        bus_rd(32'(EOC_OFF), rd);            chk("unmapped_wr_eoc", rd, 32'hF);
        bus_rd(32'(EXIT_CODE_OFF), rd);      chk("unmapped_wr_exit", rd, 32'hDEAD_0001);

        // Asynchronous reset with a request in flight
        @(negedge clk_i);
        bus.req = 1'b1; bus.we = 1'b0; bus.addr = 32'(EOC_OFF);
        #2 rst_ni = 1'b0;
        #1;
        chk("arst_eoc", eoc_o, 0);
        chk("arst_done", done_o, 0);
        chk("arst_timeout", timeout_o, 0);
        chk("arst_irq", irq_o, 0);
        @(posedge clk_i); #1;
        chk("arst_no_rvalid", bus.rvalid, 0);
        bus.req = 1'b0;
        @(negedge clk_i); rst_ni = 1'b1;
        bus_rd(32'(EXIT_CODE_OFF), rd);      chk("arst_exit", rd, 0);
        bus_rd(32'(WDT_LIMIT_OFF), rd);      chk("arst_limit", rd, 0);
        bus_rd(32'(STATUS_OFF), rd);         chk("arst_status", rd, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
